// File: rtl/mrd_mem_pkt.sv
// Shared state codes, sizing constants and the stage-count clamp used by the
// mixed-radix memory controller FSM and its optional watchdog.
package mrd_mem_pkt;

    localparam int CNT_W   = 12;
    localparam int STG_MAX = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SINK    = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_RD      = 3'd3,
        ST_WAIT_WR = 3'd4,
        ST_SOURCE  = 3'd5
    } fsm_state_t;

    // A stage count of zero still needs one pass; anything above the maximum saturates.
    function automatic logic [2:0] clamp_stages(input logic [2:0] raw);
        logic [2:0] res;
        res = raw;
        if (raw == 3'd0) begin
            res = 3'd1;
        end else if (raw > 3'(STG_MAX)) begin
            res = 3'(STG_MAX);
        end
        return res;
    endfunction

endpackage

// File: rtl/mrd_wdog.sv
// Watchdog counter for mrd_fsm_ctrl: counts stalled cycles while enabled and
// flags expiry at WDOG_CYC. Only instantiated when MRD_FSM_CTRL_WDOG_EN is set.
module mrd_wdog
    import mrd_mem_pkt::*;
#(
    parameter int WDOG_CYC = 4095
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_CYC);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Saturate at the limit so a held-off clear can never wrap past expiry.
    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (count_en && (cnt_reg != LIMIT)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign expired = count_en && (cnt_reg == LIMIT);

endmodule

// File: rtl/mrd_fsm_ctrl.sv
// Frame-level sequencer for the mixed-radix memory: sink, per-stage read/write
// passes, then source. Optional watchdog enabled by macro MRD_FSM_CTRL_WDOG_EN.
module mrd_fsm_ctrl
    import mrd_mem_pkt::*;
#(
    parameter int WAIT_RD_CYC = 8,
    parameter int WDOG_CYC    = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    input  logic [11:0] dftpts,
    input  logic [2:0]  num_stages,
    input  logic        rd_stage_done,
    input  logic        wr_stage_done,
    input  logic        source_end,
    output logic [2:0]  fsm,
    output logic [2:0]  fsm_r,
    output logic        fsm_lastRd_source,
    output logic [2:0]  stage_idx,
    output logic        sink_ready,
    output logic        err_len,
    output logic        err_timeout
);

    fsm_state_t       fsm_reg, fsm_next;
    logic [2:0]       fsm_r_reg;
    logic [2:0]       stage_reg, stage_next;
    logic [2:0]       nstg_reg, nstg_next;
    logic [CNT_W-1:0] dft_reg, dft_next;
    logic [CNT_W-1:0] smp_reg, smp_next;
    logic [CNT_W-1:0] wait_reg, wait_next;
    logic             err_len_reg, err_len_next;
    logic             err_to_reg;
    logic             sink_ready_reg;
    logic             source_reg;
    logic             pulse_used;
    logic             wdog_expired;

    always_comb begin
        fsm_next     = fsm_reg;
        stage_next   = stage_reg;
        nstg_next    = nstg_reg;
        dft_next     = dft_reg;
        smp_next     = smp_reg;
        wait_next    = '0;
        err_len_next = 1'b0;
        pulse_used   = 1'b0;
        if (wdog_expired) begin
            fsm_next = ST_IDLE;
        end else begin
            case (fsm_reg)
                ST_IDLE: begin
                    if (sink_valid && sink_sop) begin
                        fsm_next   = ST_SINK;
                        dft_next   = dftpts;
                        nstg_next  = clamp_stages(num_stages);
                        smp_next   = CNT_W'(1);
                        stage_next = 3'd0;
                    end
                end
                ST_SINK: begin
                    // A fresh sop inside a frame restarts it and flags the truncated one.
                    if (sink_valid && sink_sop) begin
                        dft_next     = dftpts;
                        nstg_next    = clamp_stages(num_stages);
                        smp_next     = CNT_W'(1);
                        stage_next   = 3'd0;
                        err_len_next = 1'b1;
                    end else if (sink_valid && sink_eop) begin
                        if (CNT_W'(smp_reg + 1'b1) == dft_reg) begin
                            fsm_next = ST_WAIT_RD;
                        end else begin
                            fsm_next     = ST_IDLE;
                            err_len_next = 1'b1;
                        end
                    end else if (sink_valid) begin
                        smp_next = smp_reg + 1'b1;
                    end
                end
                ST_WAIT_RD: begin
                    if (wait_reg == CNT_W'(WAIT_RD_CYC - 1)) begin
                        fsm_next = (stage_reg == nstg_reg - 3'd1) ? ST_SOURCE : ST_RD;
                    end else begin
                        wait_next = wait_reg + 1'b1;
                    end
                end
                ST_RD: begin
                    if (rd_stage_done && wr_stage_done) begin
                        fsm_next   = ST_WAIT_RD;
                        stage_next = stage_reg + 3'd1;
                        pulse_used = 1'b1;
                    end else if (rd_stage_done) begin
                        fsm_next   = ST_WAIT_WR;
                        pulse_used = 1'b1;
                    end
                end
                ST_WAIT_WR: begin
                    if (wr_stage_done) begin
                        fsm_next   = ST_WAIT_RD;
                        stage_next = stage_reg + 3'd1;
                        pulse_used = 1'b1;
                    end
                end
                ST_SOURCE: begin
                    if (source_end) begin
                        fsm_next   = ST_IDLE;
                        pulse_used = 1'b1;
                    end
                end
                default: fsm_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg        <= ST_IDLE;
            fsm_r_reg      <= 3'd0;
            stage_reg      <= 3'd0;
            nstg_reg       <= 3'd1;
            dft_reg        <= '0;
            smp_reg        <= '0;
            wait_reg       <= '0;
            err_len_reg    <= 1'b0;
            err_to_reg     <= 1'b0;
            sink_ready_reg <= 1'b1;
            source_reg     <= 1'b0;
        end else begin
            fsm_reg        <= fsm_next;
            fsm_r_reg      <= fsm_reg;
            stage_reg      <= stage_next;
            nstg_reg       <= nstg_next;
            dft_reg        <= dft_next;
            smp_reg        <= smp_next;
            wait_reg       <= wait_next;
            err_len_reg    <= err_len_next;
            err_to_reg     <= wdog_expired;
            sink_ready_reg <= (fsm_next == ST_IDLE) || (fsm_next == ST_SINK);
            source_reg     <= (fsm_next == ST_SOURCE);
        end
    end

`ifdef MRD_FSM_CTRL_WDOG_EN
    logic wdog_clear;
    logic wdog_en;

    // Any progress (state change or consumed done pulse) restarts the stall count.
    assign wdog_clear = (fsm_next != fsm_reg) || pulse_used;
    assign wdog_en    = (fsm_reg == ST_RD) || (fsm_reg == ST_WAIT_WR) || (fsm_reg == ST_SOURCE);

    mrd_wdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wdog_clear),
        .count_en (wdog_en),
        .expired  (wdog_expired)
    );
`else
    logic wdog_unused;

    assign wdog_expired = 1'b0;
    assign wdog_unused  = ^{pulse_used, CNT_W'(WDOG_CYC)};
`endif

    assign fsm               = fsm_reg;
    assign fsm_r             = fsm_r_reg;
    assign stage_idx         = stage_reg;
    assign fsm_lastRd_source = source_reg;
    assign sink_ready        = sink_ready_reg;
    assign err_len           = err_len_reg;
    assign err_timeout       = err_to_reg;

endmodule

// File: tb/tb_mrd_fsm_ctrl.sv
// Scoreboard bench for mrd_fsm_ctrl: stimulus pushes expected state events from a
// frame-level model, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mrd_fsm_ctrl;

    localparam int WAIT_RD_CYC = 8;
    localparam int WDOG_CYC    = 100;
    localparam int K_GOOD      = 0;
    localparam int K_ERR       = 1;
    localparam int K_RESTART   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
    logic [11:0] dftpts = '0;
    logic [2:0]  num_stages = '0;
    logic        rd_stage_done = 1'b0, wr_stage_done = 1'b0, source_end = 1'b0;
    logic [2:0]  fsm, fsm_r, stage_idx;
    logic        fsm_lastRd_source, sink_ready, err_len, err_timeout;

    mrd_fsm_ctrl #(
        .WAIT_RD_CYC (WAIT_RD_CYC),
        .WDOG_CYC    (WDOG_CYC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sink_valid        (sink_valid),
        .sink_sop          (sink_sop),
        .sink_eop          (sink_eop),
        .dftpts            (dftpts),
        .num_stages        (num_stages),
        .rd_stage_done     (rd_stage_done),
        .wr_stage_done     (wr_stage_done),
        .source_end        (source_end),
        .fsm               (fsm),
        .fsm_r             (fsm_r),
        .fsm_lastRd_source (fsm_lastRd_source),
        .stage_idx         (stage_idx),
        .sink_ready        (sink_ready),
        .err_len           (err_len),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    // One expected observable event: new state/stage or an error pulse.
    // dwell > 0 also requires the previous state to have lasted that many cycles.
    typedef struct {
        int fsm;
        int stage;
        int err_len;
        int err_to;
        int dwell;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic push_ev(input int f, input int s, input int el, input int et, input int dw);
        ev_t e;
        e.fsm = f; e.stage = s; e.err_len = el; e.err_to = et; e.dwell = dw;
        exp_q.push_back(e);
    endtask

    function automatic int clamp_ns(input int raw);
        if (raw == 0) return 1;
        if (raw > 6) return 6;
        return raw;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        int  prev_fsm;
        int  prev_stage;
        int  since;
        ev_t e;
        prev_fsm = 0; prev_stage = 0; since = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_fsm = 0; prev_stage = 0; since = 0;
                continue;
            end
            check("fsm_r_delay", int'(fsm_r), prev_fsm);
            check("sink_ready", int'(sink_ready), int'(fsm == 3'd0 || fsm == 3'd1));
            check("lastRd_source", int'(fsm_lastRd_source), int'(fsm == 3'd5));
            if (int'(fsm) != prev_fsm || int'(stage_idx) != prev_stage || err_len || err_timeout) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got fsm=%0d stage=%0d err_len=%0d err_timeout=%0d want none",
                             fsm, stage_idx, err_len, err_timeout);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_fsm", int'(fsm), e.fsm);
                    check("ev_stage", int'(stage_idx), e.stage);
                    check("ev_err_len", int'(err_len), e.err_len);
                    check("ev_err_timeout", int'(err_timeout), e.err_to);
                    if (e.dwell > 0) check("ev_dwell", since + 1, e.dwell);
                    $display("event fsm=%0d stage=%0d err_len=%0d err_to=%0d", fsm, stage_idx, err_len, err_timeout);
                end
                since = 0;
            end else begin
                since++;
            end
            prev_fsm   = int'(fsm);
            prev_stage = int'(stage_idx);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fsm(input int target, input int stg, input string name);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            if (int'(fsm) == target && (stg < 0 || int'(stage_idx) == stg)) hit = 1'b1;
            else tick();
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: got fsm=%0d stage=%0d want fsm=%0d within 300 cycles", name, fsm, stage_idx, target);
        end
    endtask

    task automatic pulse(input logic rd, input logic wr, input logic se);
        rd_stage_done = rd; wr_stage_done = wr; source_end = se;
        tick();
        rd_stage_done = 1'b0; wr_stage_done = 1'b0; source_end = 1'b0;
    endtask

    // Idle-cycle on the sink side: qualifiers garbage without valid, stray done pulses.
    task automatic gap_cycle();
        sink_valid = 1'b0;
        sink_sop   = 1'($urandom_range(0, 1));
        sink_eop   = 1'($urandom_range(0, 1));
        dftpts     = 12'($urandom);
        num_stages = 3'($urandom);
        pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic sop_beat(input int len, input int ns_raw);
        sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0;
        dftpts = 12'(len); num_stages = 3'(ns_raw);
        tick();
        sink_valid = 1'b0; sink_sop = 1'b0;
    endtask

    task automatic send_beats(input int first, input int last, input bit eop_last);
        for (int i = first; i <= last; i++) begin
            if ($urandom_range(0, 3) == 0) gap_cycle();
            sink_valid = 1'b1; sink_sop = 1'b0;
            sink_eop   = eop_last && (i == last);
            dftpts     = 12'($urandom);
            num_stages = 3'($urandom);
            tick();
        end
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    endtask

    task automatic send_frame(input int len, input int ns_raw, input int kind, input int sel);
        int at;
        wait_fsm(0, -1, "frame_idle");
        push_ev(1, 0, 0, 0, 0);
        sop_beat(len, ns_raw);
        if (kind == K_ERR) begin
            at = sel;
            if (at == 0) begin
                do at = $urandom_range(2, len + 3); while (at == len);
            end
            push_ev(0, 0, 1, 0, 0);
            send_beats(2, at, 1'b1);
        end else begin
            if (kind == K_RESTART) begin
                at = (sel == 0) ? $urandom_range(2, len) : sel;
                send_beats(2, at - 1, 1'b0);
                push_ev(1, 0, 1, 0, 0);
                sop_beat(len, ns_raw);
            end
            push_ev(2, 0, 0, 0, 0);
            send_beats(2, len, 1'b1);
        end
    endtask

    // Random wait in a state with pulses that state must ignore.
    task automatic linger(input int st);
        int n;
        n = $urandom_range(0, 3);
        repeat (n) begin
            case (st)
                3:       pulse(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                4:       pulse(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
                default: pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            endcase
        end
    endtask

    // sim_mode: 0 separate done pulses, 1 simultaneous, 2 random per stage.
    task automatic run_stages(input int ns, input int sim_mode, input int stop_stage);
        int sim;
        for (int s = 0; s < ns; s++) begin
            if (s == ns - 1) begin
                push_ev(5, s, 0, 0, WAIT_RD_CYC);
                wait_fsm(5, s, "enter_source");
                linger(5);
                push_ev(0, s, 0, 0, 0);
                pulse(1'b0, 1'b0, 1'b1);
            end else begin
                push_ev(3, s, 0, 0, WAIT_RD_CYC);
                wait_fsm(3, s, "enter_rd");
                if (s == stop_stage) break;
                linger(3);
                sim = (sim_mode == 2) ? $urandom_range(0, 1) : sim_mode;
                if (sim != 0) begin
                    push_ev(2, s + 1, 0, 0, 0);
                    pulse(1'b1, 1'b1, 1'b0);
                end else begin
                    push_ev(4, s, 0, 0, 0);
                    pulse(1'b1, 1'b0, 1'b0);
                    wait_fsm(4, s, "enter_wait_wr");
                    linger(4);
                    push_ev(2, s + 1, 0, 0, 0);
                    pulse(1'b0, 1'b1, 1'b0);
                end
            end
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        rd_stage_done = 1'b0; wr_stage_done = 1'b0; source_end = 1'b0;
        @(negedge clk);
        check({tag, "_rst_fsm"}, int'(fsm), 0);
        check({tag, "_rst_fsm_r"}, int'(fsm_r), 0);
        check({tag, "_rst_stage"}, int'(stage_idx), 0);
        check({tag, "_rst_source"}, int'(fsm_lastRd_source), 0);
        check({tag, "_rst_sink_ready"}, int'(sink_ready), 1);
        check({tag, "_rst_err_len"}, int'(err_len), 0);
        check({tag, "_rst_err_timeout"}, int'(err_timeout), 0);
        $display("reset %s applied", tag);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_noise(input int n);
        repeat (n) begin
            sink_valid = 1'b1; sink_sop = 1'b0;
            sink_eop   = 1'($urandom_range(0, 1));
            dftpts     = 12'($urandom);
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        sink_valid = 1'b0; sink_eop = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int len, nsr, kind;
        do_reset("init");
        idle_noise(3);

        send_frame(12, 1, K_GOOD, 0);           // single-stage frame
        run_stages(1, 0, -1);

        send_frame(12, 1, K_ERR, 10);           // short frame
        send_frame(12, 2, K_ERR, 14);           // long frame

        send_frame(60, 3, K_GOOD, 0);           // three-stage frame
        run_stages(3, 0, -1);

        send_frame(20, 2, K_GOOD, 0);           // simultaneous done
        run_stages(2, 1, -1);

        send_frame(15, 0, K_RESTART, 6);        // restart, stage count 0 -> 1
        run_stages(1, 0, -1);

        send_frame(9, 7, K_GOOD, 0);            // stage count 7 -> 6
        run_stages(6, 2, -1);

        send_frame(16, 3, K_GOOD, 0);           // reset while in Rd of stage 1
        run_stages(3, 0, 1);
        @(negedge clk);
        check("pre_reset_queue", exp_q.size(), 0);
        do_reset("mid_rd");
        idle_noise(4);
        send_frame(10, 2, K_GOOD, 0);
        run_stages(2, 2, -1);

        send_frame(8, 3, K_GOOD, 0);            // watchdog: stall in Rd
        run_stages(3, 0, 0);
`ifdef MRD_FSM_CTRL_WDOG_EN
        push_ev(0, 0, 0, 1, 0);
        wait_fsm(0, -1, "wdog_trip");
`else
        repeat (150) tick();
        check("wdog_off_fsm", int'(fsm), 3);
        check("wdog_off_err", int'(err_timeout), 0);
        do_reset("wdog_off");
`endif

        for (int f = 0; f < 24; f++) begin
            len  = $urandom_range(2, 40);
            nsr  = $urandom_range(0, 7);
            kind = $urandom_range(0, 5);
            if (kind == 4) begin
                send_frame(len, nsr, K_ERR, 0);
            end else begin
                send_frame(len, nsr, (kind == 5) ? K_RESTART : K_GOOD, 0);
                run_stages(clamp_ns(nsr), 2, -1);
            end
        end

        repeat (6) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mrd_fsm_ctrl.md
MRD_FSM_CTRL -- requirements
Module: mrd_fsm_ctrl

Interface
REQ-001 SHALL have parameter WAIT_RD_CYC, default 8: idle cycles spent in Wait_to_rd before each read stage.
REQ-002 SHALL have parameter WDOG_CYC, default 4095: watchdog limit in cycles (used only when REQ-030 is enabled).
REQ-003 SHALL have port clk, input, 1: single clock. The block uses one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports sink_valid, sink_sop, sink_eop, input, 1 each: input frame qualifiers.
REQ-006 SHALL have port dftpts, input, 12: frame length, sampled at an accepted sop.
REQ-007 SHALL have port num_stages, input, 3: radix stage count, sampled at an accepted sop; 0 is treated as 1 and values >6 as 6.
REQ-008 SHALL have ports rd_stage_done and wr_stage_done, input, 1 each: single-cycle pulses from the butterfly read path and the write-back path.
REQ-009 SHALL have port source_end, input, 1: single-cycle pulse at the end of output.
REQ-010 SHALL have port fsm, output, 3: current state.
REQ-011 SHALL have port fsm_r, output, 3: fsm delayed by 1 cycle.
REQ-012 SHALL have port fsm_lastRd_source, output, 1: high while fsm==Source.
REQ-013 SHALL have port stage_idx, output, 3: current read stage, 0-based.
REQ-014 SHALL have port sink_ready, output, 1: high when fsm is Idle or Sink.
REQ-015 SHALL have port err_len, output, 1: single-cycle error pulse on a bad frame length.
REQ-016 SHALL have port err_timeout, output, 1: single-cycle watchdog error pulse.

Function
REQ-017 State encoding SHALL be: Idle=0, Sink=1, Wait_to_rd=2, Rd=3, Wait_wr_end=4, Source=5; codes 6-7 SHALL go to Idle on the next cycle.
REQ-018 All outputs SHALL be registered; fsm SHALL change on the clock edge after the triggering input.
REQ-019 Idle->Sink SHALL occur on sink_valid&sink_sop; on that cycle, dftpts and num_stages are latched, the sample counter is set to 1, and stage_idx is set to 0.
REQ-020 In Sink, each sink_valid beat SHALL increment the 12-bit sample counter.
REQ-021 In Sink, on sink_valid&sink_eop with counter+1==dftpts, the state SHALL go to Wait_to_rd.
REQ-022 In Sink, on sink_valid&sink_eop with any other count, err_len SHALL pulse and the state SHALL go to Idle.
REQ-023 In Sink, a repeated sink_valid&sink_sop SHALL restart the frame: counter set to 1, err_len pulses, state stays Sink.
REQ-024 In Wait_to_rd, the block SHALL count WAIT_RD_CYC cycles, then go to Source if stage_idx==num_stages-1, else to Rd.
REQ-025 Rd->Wait_wr_end SHALL occur on rd_stage_done.
REQ-026 If rd_stage_done and wr_stage_done arrive in the same cycle in Rd, the state SHALL go directly to Wait_to_rd with stage_idx+1.
REQ-027 Wait_wr_end->Wait_to_rd SHALL occur on wr_stage_done, with stage_idx incremented.
REQ-028 Source->Idle SHALL occur on source_end.
REQ-029 done or source_end pulses received in any state other than the one that consumes them SHALL be ignored.

Configuration
REQ-030 When macro MRD_FSM_CTRL_WDOG_EN is defined, a counter SHALL clear on every state change and on every consumed pulse, and SHALL count while in Rd, Wait_wr_end or Source.
REQ-031 With MRD_FSM_CTRL_WDOG_EN defined, when the counter reaches WDOG_CYC, err_timeout SHALL pulse and the state SHALL go to Idle.
REQ-032 Without MRD_FSM_CTRL_WDOG_EN, no watchdog counter SHALL exist and err_timeout SHALL be constant 0.

Reset
REQ-033 While rst_n is low, the outputs SHALL be: fsm=Idle, fsm_r=Idle, stage_idx=0, fsm_lastRd_source=0, sink_ready=1, err_len=0, err_timeout=0.
REQ-034 Reset assertion mid-frame SHALL abandon the frame immediately; after release the block SHALL wait for a fresh sop.

Structure
REQ-035 State codes (3-bit), stage-count maximum (6) and counter width (12) SHALL live in package mrd_mem_pkt.
REQ-036 The optional watchdog SHALL be a sub-module mrd_wdog, instantiated only under MRD_FSM_CTRL_WDOG_EN.

Verification
REQ-037 Single-stage frame: dftpts=12, num_stages=1, 12 beats with sop/eop -> fsm sequence 0,1,2(8 cycles),5; fsm_lastRd_source=1 in Source; source_end -> fsm=0.
REQ-038 Three-stage frame: dftpts=60, num_stages=3, done pulses per stage -> stage_idx steps 0,1,2; Source entered after the second wr_stage_done.
REQ-039 Short frame: eop on beat 10 with dftpts=12 -> err_len pulses once and fsm=0 on the next cycle.
REQ-040 Simultaneous done: rd_stage_done and wr_stage_done in the same cycle in Rd -> fsm goes 3->2 and stage_idx increments.
REQ-041 Reset mid-Rd: rst_n low at stage 1 -> all outputs at reset values on the next sampled edge; a new sop is accepted after release.
REQ-042 Watchdog (macro on, WDOG_CYC=100): no rd_stage_done for 100 cycles in Rd -> err_timeout pulses and fsm=0; with the macro off, fsm stays 3.
